// File: rtl/kfmmc_pkg.sv
// kfmmc_pkg: shared types and constants for the KFMMC sector streamer.
//   streamer_state_t : top-level FSM encoding
//   SECTOR_BYTES     : bytes moved per command
//   CNT_W            : width of the byte counters (holds 0..SECTOR_BYTES)
package kfmmc_pkg;

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} streamer_state_t;

  localparam int SECTOR_BYTES = 512;
  localparam int CNT_W        = 10;

endpackage

// File: rtl/kfmmc_byte_fifo.sv
// kfmmc_byte_fifo: synchronous byte FIFO decoupling host and drive sides.
//   clock, reset : clock, asynchronous active-low reset
//   push, din    : write request and data (accepted when not full, or when
//                  a pop in the same cycle frees the slot)
//   pop, dout    : read request and head-of-queue data (dout is the head)
//   flush        : drops all contents; wins over push/pop
//   full, empty  : status
//   level        : current occupancy, 0..DEPTH
module kfmmc_byte_fifo #(
  parameter  int DEPTH = 16,
  parameter  int W     = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  input  logic          flush,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;
  logic         do_push, do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level   = wr_ptr - rd_ptr;
  assign empty   = (level == '0);
  assign full    = level[AW];
  assign dout    = mem[rd_ptr[AW-1:0]];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/kfmmc_sector_streamer.sv
// kfmmc_sector_streamer: host-side byte pump for KFMMC_Drive, one 512-byte
// sector per command.
//   clock, reset          : clock, asynchronous active-low reset
//   cmd_valid/cmd_write   : start a sector transfer (1 = host->drive)
//   cmd_ready             : high only while idle
//   abort                 : cancel the active transfer (no done pulse)
//   host_in_*             : write-mode byte stream from host (valid/ready)
//   host_out_*            : read-mode byte stream to host (valid/ready)
//   done                  : one-cycle pulse at sector completion
//   internal_data_bus     : byte to drive, qualified by write_data
//   write_data/read_data  : registered one-cycle drive strobes
//   drive_rdata           : drive byte, READ_LATENCY cycles after read_data
//   drive_busy            : holds off new strobes
//   terminal_count        : accompanies the 512th strobe
module kfmmc_sector_streamer
  import kfmmc_pkg::*;
#(
  parameter int FIFO_DEPTH   = 16,
  parameter int STROBE_GAP   = 2,
  parameter int READ_LATENCY = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic       cmd_write,
  output logic       cmd_ready,
  input  logic       abort,
  input  logic [7:0] host_in_data,
  input  logic       host_in_valid,
  output logic       host_in_ready,
  output logic [7:0] host_out_data,
  output logic       host_out_valid,
  input  logic       host_out_ready,
  output logic       done,
  output logic [7:0] internal_data_bus,
  output logic       write_data,
  output logic       read_data,
  input  logic [7:0] drive_rdata,
  input  logic       drive_busy,
  output logic       terminal_count
);

  localparam int                LW       = $clog2(FIFO_DEPTH) + 1;
  localparam int                STAGES   = READ_LATENCY;
  localparam logic [CNT_W-1:0]  CNT_END  = CNT_W'(SECTOR_BYTES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SECTOR_BYTES - 1);

  streamer_state_t  state_q, state_d;
  logic             busy_q;
  logic [7:0]       gap_q;
  logic [CNT_W-1:0] out_cnt, in_cnt;
  // vld_pipe[0] is the read_data strobe itself; vld_pipe[STAGES] marks the
  // cycle in which drive_rdata holds the byte for that strobe.
  logic [STAGES:0]  vld_pipe;
  logic [2:0]       in_flight;

  logic             fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [7:0]       fifo_din, fifo_dout;
  logic [LW-1:0]    fifo_level;

  logic             strobe_ok, credit_ok, wr_strobe, rd_strobe, cmd_take;

  kfmmc_byte_fifo #(.DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .din   (fifo_din),
    .pop   (fifo_pop),
    .flush (fifo_flush),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Strobes issued but not yet captured into the FIFO.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i <= STAGES; i++) in_flight = in_flight + 3'(vld_pipe[i]);
  end

  // Every issued read strobe must have a FIFO slot reserved, so the capture
  // path never sees a full FIFO regardless of host back-pressure.
  assign credit_ok = (int'(fifo_level) + int'(in_flight)) < FIFO_DEPTH;
  // Busy is judged on the registered copy: a busy that rises in the decision
  // cycle does not suppress that strobe.
  assign strobe_ok = !busy_q && (gap_q == 8'd0) && !abort;
  assign cmd_take  = (state_q == IDLE) && cmd_valid;

  // ---- FSM: state register ----
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (cmd_valid) state_d = cmd_write ? WRITE : READ;
      WRITE: if (abort) state_d = IDLE;
             else if (out_cnt == CNT_END) state_d = DONE;
      READ:  if (abort) state_d = IDLE;
             else if (out_cnt == CNT_END) state_d = DRAIN;
      DRAIN: if (abort) state_d = IDLE;
             else if (in_flight == 3'd0 && fifo_empty) state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---- FSM: outputs and strobe decisions ----
  always_comb begin
    cmd_ready      = (state_q == IDLE);
    done           = (state_q == DONE);
    host_in_ready  = 1'b0;
    host_out_valid = 1'b0;
    wr_strobe      = 1'b0;
    rd_strobe      = 1'b0;
    case (state_q)
      WRITE: begin
        wr_strobe     = strobe_ok && !fifo_empty && (out_cnt != CNT_END);
        // A drive pop in the same cycle frees the slot a full FIFO needs.
        host_in_ready = (!fifo_full || wr_strobe) && (in_cnt != CNT_END);
      end
      READ: begin
        rd_strobe      = strobe_ok && credit_ok && (out_cnt != CNT_END);
        host_out_valid = !fifo_empty;
      end
      DRAIN: host_out_valid = !fifo_empty;
      default: ;
    endcase
  end

  assign fifo_flush    = abort && (state_q != IDLE);
  assign fifo_pop      = wr_strobe || (host_out_valid && host_out_ready);
  assign fifo_push     = (host_in_valid && host_in_ready) ||
                         (vld_pipe[STAGES] && (state_q == READ || state_q == DRAIN));
  assign fifo_din      = (state_q == WRITE) ? host_in_data : drive_rdata;
  assign host_out_data = fifo_dout;
  assign read_data     = vld_pipe[0];

  // ---- pacing, counters, registered drive outputs ----
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy_q            <= 1'b0;
      gap_q             <= '0;
      out_cnt           <= '0;
      in_cnt            <= '0;
      vld_pipe          <= '0;
      write_data        <= 1'b0;
      internal_data_bus <= '0;
      terminal_count    <= 1'b0;
    end else begin
      busy_q         <= drive_busy;
      write_data     <= wr_strobe;
      terminal_count <= (wr_strobe || rd_strobe) && (out_cnt == CNT_LAST);
      if (wr_strobe) internal_data_bus <= fifo_dout;

      if (wr_strobe || rd_strobe) gap_q <= 8'(STROBE_GAP);
      else if (gap_q != 8'd0)     gap_q <= gap_q - 8'd1;

      if (cmd_take) begin
        out_cnt <= '0;
        in_cnt  <= '0;
      end else begin
        if ((wr_strobe || rd_strobe) && out_cnt != CNT_END) out_cnt <= out_cnt + CNT_W'(1);
        if (fifo_push && in_cnt != CNT_END)                  in_cnt  <= in_cnt + CNT_W'(1);
      end

      // Abort discards captures still in the latency pipe.
      if (fifo_flush) vld_pipe <= '0;
      else            vld_pipe <= {vld_pipe[STAGES-1:0], rd_strobe};
    end
  end

endmodule
